// File: rtl/imul_pkg.sv
// imul_pkg: shared widths and sequencer state encoding for the chunked 32x32 multiply front end
//   CHUNK_W  - bits of operand A fed to the 8x32 multiplier per operation
//   NCHUNK   - number of A chunks (A width = CHUNK_W*NCHUNK)
//   B_W      - operand B width, equal to the multiplier B width
//   P_PART_W - width of one multiplier partial product
//   P_W      - width of the full product
package imul_pkg;
  localparam int CHUNK_W = 8;
  localparam int NCHUNK = 4;
  localparam int B_W = 32;
  localparam int P_PART_W = CHUNK_W + B_W;
  localparam int P_W = CHUNK_W * NCHUNK + B_W;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/imul_partial_acc.sv
// imul_partial_acc: product accumulator adding each partial product at its chunk position
//   clk, reset - clock and asynchronous active-low reset
//   clr        - zero the accumulator (new request)
//   en         - add part << CHUNK_W*idx into the accumulator
//   idx, part  - chunk index and partial product of the committing operation
//   sum        - accumulator value including the current partial product
module imul_partial_acc
  import imul_pkg::*;
#(
  parameter int PART_W = P_PART_W,
  parameter int ACC_W = P_W,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [PART_W-1:0] part,
  output logic [ACC_W-1:0]  sum
);
  logic [ACC_W-1:0] acc;
  // the shifted partial product always fits: A*B never exceeds ACC_W bits
  assign sum = acc + (ACC_W'(part) << (CHUNK_W * idx));
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= sum;
endmodule

// File: rtl/imul_op_sequencer.sv
// imul_op_sequencer: splits a 32x32 multiply into 8x32 multiplier operations and shift-accumulates the result
//   clk, reset                      - clock and asynchronous active-low reset
//   req_val/req_rdy, req_a, req_b   - multiply request
//   resp_val/resp_rdy, resp_p       - product response, held until consumed
//   mul_a, mul_b, mul_val_op        - operands and start pulse to the iterative multiplier
//   mul_p, mul_commit               - multiplier partial product and its completion pulse
module imul_op_sequencer
  import imul_pkg::*;
#(
  parameter int NCHUNK = imul_pkg::NCHUNK,
  parameter int B_W = imul_pkg::B_W,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_val,
  output logic                         req_rdy,
  input  logic [CHUNK_W*NCHUNK-1:0]    req_a,
  input  logic [B_W-1:0]               req_b,
  output logic                         resp_val,
  input  logic                         resp_rdy,
  output logic [CHUNK_W*NCHUNK+B_W-1:0] resp_p,
  output logic [CHUNK_W-1:0]           mul_a,
  output logic [B_W-1:0]               mul_b,
  output logic                         mul_val_op,
  input  logic [CHUNK_W+B_W-1:0]       mul_p,
  input  logic                         mul_commit
);
  localparam int A_W = CHUNK_W * NCHUNK;
  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PART_W = CHUNK_W + B_W;
  localparam int ACC_W = A_W + B_W;

  state_t state;
  logic [A_W-1:0] cap_a;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0] first, nxt;
  logic [ACC_W-1:0] sum;
  logic clr, en;

  function automatic logic [CHUNK_W-1:0] chunk(input logic [A_W-1:0] a, input logic [IDX_W-1:0] i);
    return a[CHUNK_W * i +: CHUNK_W];
  endfunction

  // {found, index} of the lowest chunk at or above start that must be issued
  function automatic logic [IDX_W:0] pick(input logic [A_W-1:0] a, input int start);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NCHUNK - 1; i >= 0; i--)
      if (i >= start && (SKIP_ZERO == 1'b0 || a[CHUNK_W * i +: CHUNK_W] != '0)) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  assign req_rdy = state == IDLE;
  assign clr = req_rdy && req_val;
  assign en = state == WAIT && mul_commit;
  assign first = pick(req_a, 0);
  assign nxt = pick(cap_a, int'(idx) + 1);

  imul_partial_acc #(
    .PART_W(PART_W),
    .ACC_W (ACC_W),
    .IDX_W (IDX_W)
  ) u_acc (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (en),
    .idx  (idx),
    .part (mul_p),
    .sum  (sum)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      cap_a      <= '0;
      idx        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_val_op <= 1'b0;
      resp_val   <= 1'b0;
      resp_p     <= '0;
    end else begin
      case (state)
        IDLE:
          if (req_val) begin
            cap_a <= req_a;
            mul_b <= req_b;
            if (first[IDX_W]) begin
              idx        <= first[IDX_W-1:0];
              mul_a      <= chunk(req_a, first[IDX_W-1:0]);
              mul_val_op <= 1'b1;
              state      <= ISSUE;
            end else begin
              resp_p   <= '0;
              resp_val <= 1'b1;
              state    <= RESP;
            end
          end
        ISSUE: begin
          mul_val_op <= 1'b0;
          state      <= WAIT;
        end
        WAIT:
          if (mul_commit) begin
            if (nxt[IDX_W]) begin
              idx        <= nxt[IDX_W-1:0];
              mul_a      <= chunk(cap_a, nxt[IDX_W-1:0]);
              mul_val_op <= 1'b1;
              state      <= ISSUE;
            end else begin
              resp_p   <= sum;
              resp_val <= 1'b1;
              state    <= RESP;
            end
          end
        RESP:
          if (resp_rdy) begin
            resp_val <= 1'b0;
            state    <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_imul_op_sequencer.sv
// tb_imul_op_sequencer: directed vectors against two sequencers (zero skipping on/off) with a fixed-latency multiplier model
module tb_imul_op_sequencer;
  localparam int L = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic req_val[2], req_rdy[2], resp_val[2], resp_rdy[2];
  logic mul_val_op[2], mul_commit[2], force_commit[2], busy[2];
  logic [31:0] req_a[2], req_b[2], mul_b[2], last_b[2];
  logic [63:0] resp_p[2];
  logic [7:0] mul_a[2], last_a[2];
  logic [39:0] mul_p[2];
  int cnt[2], pulses[2], overlap[2];
  int total = 0, bad = 0;

  imul_op_sequencer u0 (
    .clk(clk), .reset(rst_n),
    .req_val(req_val[0]), .req_rdy(req_rdy[0]), .req_a(req_a[0]), .req_b(req_b[0]),
    .resp_val(resp_val[0]), .resp_rdy(resp_rdy[0]), .resp_p(resp_p[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_val_op(mul_val_op[0]),
    .mul_p(mul_p[0]), .mul_commit(mul_commit[0])
  );

  imul_op_sequencer #(.SKIP_ZERO(1'b0)) u1 (
    .clk(clk), .reset(rst_n),
    .req_val(req_val[1]), .req_rdy(req_rdy[1]), .req_a(req_a[1]), .req_b(req_b[1]),
    .resp_val(resp_val[1]), .resp_rdy(resp_rdy[1]), .resp_p(resp_p[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_val_op(mul_val_op[1]),
    .mul_p(mul_p[1]), .mul_commit(mul_commit[1])
  );

  // multiplier model: commit arrives L cycles after the val_op cycle
  always @(posedge clk or negedge rst_n)
    for (int g = 0; g < 2; g++)
      if (!rst_n) begin
        busy[g] <= 1'b0;
        cnt[g]  <= 0;
      end else if (mul_val_op[g]) begin
        overlap[g] <= overlap[g] + int'(busy[g]);
        busy[g]    <= 1'b1;
        cnt[g]     <= L - 1;
        mul_p[g]   <= 40'(mul_a[g]) * 40'(mul_b[g]);
        pulses[g]  <= pulses[g] + 1;
        last_a[g]  <= mul_a[g];
        last_b[g]  <= mul_b[g];
      end else if (busy[g]) begin
        if (cnt[g] == 0) busy[g] <= 1'b0;
        else cnt[g] <= cnt[g] - 1;
      end

  always_comb
    for (int g = 0; g < 2; g++) mul_commit[g] = (busy[g] && cnt[g] == 0) || force_commit[g];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic run(input int u, input logic [31:0] a, input logic [31:0] b,
                     output logic [63:0] p, output int iss, output int lat);
    int k, p0;
    k = 0;
    while (!req_rdy[u] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("req_rdy_before", 64'(req_rdy[u]), 64'd1);
    req_a[u] = a;
    req_b[u] = b;
    req_val[u] = 1'b1;
    p0 = pulses[u];
    @(negedge clk);
    req_val[u] = 1'b0;
    lat = 1;
    while (!resp_val[u] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    p = resp_p[u];
    iss = pulses[u] - p0;
    resp_rdy[u] = 1'b1;
    @(negedge clk);
    resp_rdy[u] = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int iss;
    int lat;
    logic [7:0] la;
  } vec_t;

  vec_t tv[8];

  initial begin
    logic [63:0] p;
    int iss, lat, k, p0;
    tv[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 1, 11, 8'h03};
    tv[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4, 41, 8'hFF};
    tv[2] = '{32'h0000_0000, 32'h0000_1234, 64'h0,                   0, 1,  8'h00};
    tv[3] = '{32'h0100_0100, 32'h0000_0010, 64'h0000_0000_1000_1000, 2, 21, 8'h01};
    tv[4] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1, 11, 8'h80};
    tv[5] = '{32'h00FF_0000, 32'h0000_0100, 64'h0000_0000_FF00_0000, 1, 11, 8'hFF};
    tv[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 4, 41, 8'hFF};
    tv[7] = '{32'h0002_0003, 32'h0001_0000, 64'h0000_0002_0003_0000, 2, 21, 8'h02};
    for (int g = 0; g < 2; g++) begin
      req_val[g] = 1'b0;
      resp_rdy[g] = 1'b0;
      force_commit[g] = 1'b0;
      req_a[g] = '0;
      req_b[g] = '0;
    end
    rst_n = 1'b0;
    #12;
    chk("rst_req_rdy", 64'(req_rdy[0]), 64'd1);
    chk("rst_resp_val", 64'(resp_val[0]), 64'd0);
    chk("rst_resp_p", resp_p[0], 64'd0);
    chk("rst_val_op", 64'(mul_val_op[0]), 64'd0);
    chk("rst_mul_a", 64'(mul_a[0]), 64'd0);
    chk("rst_mul_b", 64'(mul_b[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run(0, tv[i].a, tv[i].b, p, iss, lat);
      chk($sformatf("v%0d_p", i), p, tv[i].p);
      chk($sformatf("v%0d_issues", i), 64'(iss), 64'(tv[i].iss));
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(tv[i].lat));
      if (tv[i].iss > 0) begin
        chk($sformatf("v%0d_mul_a", i), 64'(last_a[0]), 64'(tv[i].la));
        chk($sformatf("v%0d_mul_b", i), 64'(last_b[0]), 64'(tv[i].b));
      end
    end

    run(1, 32'h0, 32'h1234, p, iss, lat);
    chk("noskip_zero_p", p, 64'd0);
    chk("noskip_zero_issues", 64'(iss), 64'd4);
    chk("noskip_zero_lat", 64'(lat), 64'd41);
    run(1, 32'h3, 32'h5, p, iss, lat);
    chk("noskip_small_p", p, 64'hF);
    chk("noskip_small_issues", 64'(iss), 64'd4);

    req_a[0] = 32'd7;
    req_b[0] = 32'd6;
    req_val[0] = 1'b1;
    p0 = pulses[0];
    @(negedge clk);
    req_val[0] = 1'b0;
    k = 0;
    while (!resp_val[0] && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("bp_first_p", resp_p[0], 64'd42);
    for (int c = 0; c < 10; c++) begin
      req_val[0] = 1'b1;
      req_a[0] = 32'd9;
      req_b[0] = 32'd9;
      @(negedge clk);
      chk($sformatf("bp_hold_val%0d", c), 64'(resp_val[0]), 64'd1);
      chk($sformatf("bp_hold_p%0d", c), resp_p[0], 64'd42);
      chk($sformatf("bp_hold_rdy%0d", c), 64'(req_rdy[0]), 64'd0);
    end
    req_val[0] = 1'b0;
    chk("bp_no_extra_issue", 64'(pulses[0] - p0), 64'd1);
    resp_rdy[0] = 1'b1;
    @(negedge clk);
    resp_rdy[0] = 1'b0;
    chk("bp_release_val", 64'(resp_val[0]), 64'd0);
    chk("bp_release_rdy", 64'(req_rdy[0]), 64'd1);
    run(0, 32'd9, 32'd9, p, iss, lat);
    chk("bp_next_p", p, 64'd81);
    chk("bp_next_issues", 64'(iss), 64'd1);

    req_a[0] = 32'hFFFF_FFFF;
    req_b[0] = 32'hFFFF_FFFF;
    req_val[0] = 1'b1;
    p0 = pulses[0];
    @(negedge clk);
    req_val[0] = 1'b0;
    k = 0;
    while (pulses[0] - p0 < 2 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("rw_second_issue", 64'(pulses[0] - p0), 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw_req_rdy", 64'(req_rdy[0]), 64'd1);
    chk("rw_resp_val", 64'(resp_val[0]), 64'd0);
    chk("rw_resp_p", resp_p[0], 64'd0);
    chk("rw_val_op", 64'(mul_val_op[0]), 64'd0);
    chk("rw_mul_a", 64'(mul_a[0]), 64'd0);
    chk("rw_mul_b", 64'(mul_b[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses[0];
    force_commit[0] = 1'b1;
    @(negedge clk);
    force_commit[0] = 1'b0;
    @(negedge clk);
    chk("stray_req_rdy", 64'(req_rdy[0]), 64'd1);
    chk("stray_resp_val", 64'(resp_val[0]), 64'd0);
    chk("stray_no_issue", 64'(pulses[0] - p0), 64'd0);
    run(0, 32'd2, 32'd3, p, iss, lat);
    chk("after_rst_p", p, 64'd6);
    chk("after_rst_issues", 64'(iss), 64'd1);
    chk("after_rst_lat", 64'(lat), 64'd11);

    chk("no_overlap", 64'(overlap[0] + overlap[1]), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imul_op_sequencer.md
Name: imul_op_sequencer

Overview:
- Sits directly upstream of the iterative 8x32 integer multiplier and drives its operand inputs and its val_op/commit handshake.
- Accepts a full 32x32 unsigned multiply request and slices operand A into four 8-bit chunks.
- Issues one multiplier operation per non-zero chunk and shift-accumulates each 40-bit partial product into a 64-bit result.
- Returns that result on a valid/ready response interface.

Parameters:
- NCHUNK, 4: number of 8-bit chunks of operand A; A width = 8*NCHUNK.
- B_W, 32: operand B width; must equal the multiplier B width.
- SKIP_ZERO, 1: when 1, chunks equal to 0x00 are not issued to the multiplier.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_a  in  32  multiplicand A.
- req_b  in  32  multiplier B.
- resp_val  out  1  result valid.
- resp_rdy  in  1  result consumed.
- resp_p  out  64  product A*B.
- mul_a  out  8  current A chunk to multiplier.
- mul_b  out  32  B to multiplier.
- mul_val_op  out  1  one-cycle start pulse to multiplier.
- mul_p  in  40  multiplier product.
- mul_commit  in  1  one-cycle pulse; mul_p valid in the same cycle.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; acc, captured A/B, chunk index, mul_a, mul_b, resp_p = 0; resp_val=0; mul_val_op=0.
  - req_rdy = (state==IDLE), so it reads 1 during reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_rdy=1.
  - On req_val: capture req_a/req_b and clear acc.
  - Select the lowest chunk index i with byte i of req_a != 0; with SKIP_ZERO=0, i=0 always.
  - If such i exists: load mul_a=byte i, mul_b=req_b, idx=i, go to ISSUE.
  - Otherwise: go to RESP with resp_p=0. resp_val is high the cycle after the accept.
- ISSUE:
  - mul_val_op=1 for exactly this cycle. Then WAIT.
- WAIT:
  - mul_a/mul_b are held stable.
  - On mul_commit: acc <= acc + (zero-extended mul_p << 8*idx).
  - Find the next index j > idx with a non-zero captured byte (or j = idx+1 when SKIP_ZERO=0).
  - If j exists: mul_a=byte j, idx=j, go to ISSUE.
  - Otherwise: resp_p <= updated acc, go to RESP.
- RESP:
  - resp_val=1; resp_p is held stable until resp_rdy=1.
  - On the handshake: go to IDLE. req_rdy rises the next cycle; there is no same-cycle response/request bypass.
- Width rule:
  - Partial product < 2^40; shifted by ≤24 it is < 2^64.
  - The final sum equals A*B < 2^64, so the 64-bit acc never overflows. No truncation occurs anywhere.
- Latency:
  - Let L = cycles from the val_op cycle to the commit cycle.
  - Accept to resp_val = sum over issued chunks of (1+L), plus 1.
  - Example: 4 chunks with L=9 gives 41 cycles.
- mul_commit outside WAIT: ignored; acc and state are unchanged.
- mul_commit is never expected in ISSUE: val_op and commit cannot coincide.
- req_val while not IDLE: ignored; req_rdy=0.
- Reset mid-operation: immediate return to IDLE and all registers cleared. A late mul_commit after reset release is ignored, since the block is in IDLE.
- mul_val_op is never asserted while a multiplier operation is outstanding.

Decomposition:
- Shared package imul_pkg: CHUNK_W=8, NCHUNK, B_W, P_PART_W=40, P_W=64, and the sequencer state enum (IDLE/ISSUE/WAIT/RESP).
- One natural sub-module, imul_partial_acc: a 64-bit accumulator with clear, and add of (mul_p << 8*idx) on an enable.
- Chunk selection (next non-zero index) and the FSM stay in the top level.

Test Plan:
- Single chunk: A=0x00000003, B=5 → exactly one mul_val_op with mul_a=0x03, mul_b=5; resp_p=0x000000000000000F.
- All chunks: A=0xFFFFFFFF, B=0xFFFFFFFF → four val_op pulses with idx 0..3 and mul_a=0xFF; resp_p=0xFFFFFFFE00000001; latency 4*(1+L)+1.
- Zero operand: A=0x00000000, B=0x1234 → no mul_val_op; resp_val the cycle after accept with resp_p=0. Also repeat with SKIP_ZERO=0 → four issues, resp_p=0.
- Sparse chunks: A=0x01000100, B=0x10 → issues only idx 1 and idx 3 (mul_a=0x01 each); resp_p=0x0000000010001000.
- Backpressure: resp_rdy held 0 for 10 cycles after resp_val → resp_val/resp_p stable, req_rdy=0, new req_val not accepted. Release → IDLE next cycle; the next request is accepted.
- Reset in WAIT: reset pulled low during the 2nd chunk of A=0xFFFFFFFF → all outputs at reset values immediately. A stray mul_commit after release causes no state change. A following request A=2, B=3 returns resp_p=6.
